// File: rtl/bram_i2s_pkg.sv
// Shared constants for the BRAM-to-I2S playback path.
package bram_i2s_pkg;
  localparam int unsigned SLOTS_PER_FRAME = 64;
  localparam int unsigned SLOTS_PER_CH    = 32;
  localparam int unsigned SAMPLE_W        = 16;

  function automatic int unsigned frame_len(input int unsigned bclk_div);
    return SLOTS_PER_FRAME * bclk_div;
  endfunction
endpackage

// File: rtl/bram_i2s_player_i2s_tx.sv
// I2S transmitter: frame counter, MCLK/BCLK/LRCLK generation and MSB-first
// serialisation of a stereo word, all outputs registered with one clk delay.
module i2s_tx
  import bram_i2s_pkg::*;
#(
  parameter int unsigned MCLK_DIV = 8,
  parameter int unsigned BCLK_DIV = 32
) (
  input  logic                    clk,
  input  logic                    rstn,
  input  logic [2*SAMPLE_W-1:0]   sample,
  output logic                    frame_end,
  output logic                    mclk,
  output logic                    bclk,
  output logic                    lrclk,
  output logic                    dacdat
);
  localparam int unsigned FRAME = frame_len(BCLK_DIV);
  localparam int unsigned CNT_W = $clog2(FRAME);
  localparam int unsigned IDX_W = $clog2(SAMPLE_W);

  logic [CNT_W-1:0]           cnt;
  logic [31:0]                cnt_w;
  logic [31:0]                slot;
  logic [31:0]                ph;
  logic signed [SAMPLE_W-1:0] left_s;
  logic signed [SAMPLE_W-1:0] right_s;
  logic mclk_p0, bclk_p0, lrclk_p0, dacdat_p0;
  logic mclk_p1, bclk_p1, lrclk_p1, dacdat_p1;

  assign left_s    = sample[2*SAMPLE_W-1:SAMPLE_W];
  assign right_s   = sample[SAMPLE_W-1:0];
  assign frame_end = (cnt == CNT_W'(FRAME - 1));

  always_ff @(posedge clk) begin
    if (!rstn) begin
      cnt <= '0;
    end else begin
      cnt <= frame_end ? '0 : cnt + CNT_W'(1);
    end
  end

  // Stage p0: combinational decode of the frame position
  always_comb begin
    cnt_w     = 32'(cnt);
    slot      = cnt_w / BCLK_DIV;
    ph        = cnt_w % BCLK_DIV;
    mclk_p0   = (cnt_w % MCLK_DIV) >= (MCLK_DIV / 2);
    bclk_p0   = ph >= (BCLK_DIV / 2);
    lrclk_p0  = slot >= SLOTS_PER_CH;
    dacdat_p0 = 1'b0;
    // One-slot I2S delay: slot 1 carries the MSB of each channel
    if (slot >= 1 && slot <= SAMPLE_W) begin
      dacdat_p0 = left_s[IDX_W'(SAMPLE_W - slot)];
    end else if (slot >= SLOTS_PER_CH + 1 && slot <= SLOTS_PER_CH + SAMPLE_W) begin
      dacdat_p0 = right_s[IDX_W'(SLOTS_PER_CH + SAMPLE_W - slot)];
    end
  end

  // Stage p1: registered pins, equal latency for every output
  always_ff @(posedge clk) begin
    if (!rstn) begin
      mclk_p1   <= 1'b0;
      bclk_p1   <= 1'b0;
      lrclk_p1  <= 1'b0;
      dacdat_p1 <= 1'b0;
    end else begin
      mclk_p1   <= mclk_p0;
      bclk_p1   <= bclk_p0;
      lrclk_p1  <= lrclk_p0;
      dacdat_p1 <= dacdat_p0;
    end
  end

  assign mclk   = mclk_p1;
  assign bclk   = bclk_p1;
  assign lrclk  = lrclk_p1;
  assign dacdat = dacdat_p1;
endmodule

// File: rtl/bram_i2s_player.sv
// Audio playback top: walks a BRAM one word per frame and hands each stereo
// word to the I2S transmitter for the following frame.
module bram_i2s_player
  import bram_i2s_pkg::*;
#(
  parameter int unsigned MCLK_DIV = 8,
  parameter int unsigned BCLK_DIV = 32,
  parameter int unsigned DEPTH    = 65536
) (
  input  logic        clk,
  input  logic        rstn,
  output logic [31:0] bram_addra,
  input  logic [31:0] bram_douta,
  output logic        mclk,
  output logic        bclk,
  output logic        lrclk,
  output logic        dacdat
);
  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [AW-1:0]           addr_q;
  logic [2*SAMPLE_W-1:0]   sample_q;
  logic                    frame_end;

  // Address is held for a whole frame, so the registered read data is settled
  // well before the latch on the last cycle of the frame.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      addr_q   <= '0;
      sample_q <= '0;
    end else if (frame_end) begin
      sample_q <= bram_douta;
      addr_q   <= (addr_q == AW'(DEPTH - 1)) ? '0 : addr_q + AW'(1);
    end
  end

  assign bram_addra = 32'(addr_q);

  i2s_tx #(
    .MCLK_DIV (MCLK_DIV),
    .BCLK_DIV (BCLK_DIV)
  ) u_tx (
    .clk       (clk),
    .rstn      (rstn),
    .sample    (sample_q),
    .frame_end (frame_end),
    .mclk      (mclk),
    .bclk      (bclk),
    .lrclk     (lrclk),
    .dacdat    (dacdat)
  );
endmodule

// File: tb/tb_bram_i2s_player.sv
// Bench for bram_i2s_player: two instances (full depth and DEPTH=4) fed by
// registered BRAM models, checked against a frame-level reference model.
module tb_bram_i2s_player;
  localparam longint MCLK  = 8;
  localparam longint BCLK  = 32;
  localparam longint FRAME = 64 * BCLK;
  localparam longint D1    = 65536;
  localparam longint D2    = 4;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic [31:0] addr1, douta1, addr2, douta2;
  logic        mclk1, bclk1, lrclk1, dac1;
  logic        mclk2, bclk2, lrclk2, dac2;
  logic [31:0] mem [0:63];
  longint      kk = 0;
  int          checks = 0;
  int          errors = 0;

  always #5 clk = ~clk;

  bram_i2s_player dut (
    .clk(clk), .rstn(rstn), .bram_addra(addr1), .bram_douta(douta1),
    .mclk(mclk1), .bclk(bclk1), .lrclk(lrclk1), .dacdat(dac1)
  );

  bram_i2s_player #(.DEPTH(4)) dut_wrap (
    .clk(clk), .rstn(rstn), .bram_addra(addr2), .bram_douta(douta2),
    .mclk(mclk2), .bclk(bclk2), .lrclk(lrclk2), .dacdat(dac2)
  );

  // BRAM models with one cycle of registered read latency
  always @(posedge clk) begin
    douta1 <= mem[addr1[5:0]];
    douta2 <= mem[addr2[5:0]];
  end

  // Clock edges since the last edge that saw reset asserted
  always @(posedge clk) kk <= rstn ? kk + 1 : 0;

  // Reference: after k edges the pins show position k-1 of the frame timeline;
  // frame 0 is silent, frame f plays mem[(f-1) mod depth].
  function automatic void model(input longint k, input longint depth,
                                output logic [3:0] pins, output logic [31:0] addr);
    longint p, f, c, s;
    logic [31:0] w, t;
    pins = '0;
    addr = '0;
    if (k > 0) begin
      p = k - 1;
      f = p / FRAME;
      c = p % FRAME;
      s = c / BCLK;
      w = (f == 0) ? 32'h0 : mem[int'((f - 1) % depth)];
      t = 32'h0;
      if (s >= 1 && s <= 16) t = w >> (32 - s);
      else if (s >= 33 && s <= 48) t = w >> (48 - s);
      pins = {((c % MCLK) >= MCLK / 2), ((c % BCLK) >= BCLK / 2), (s >= 32), t[0]};
      addr = 32'((k / FRAME) % depth);
    end
  endfunction

  task automatic do_reset(input int n);
    @(negedge clk);
    rstn = 1'b0;
    repeat (n) @(negedge clk);
    rstn = 1'b1;
  endtask

  task automatic test_reset();
    rstn = 1'b0;
    repeat (10) @(negedge clk);
    checks++;
    if ({mclk1, bclk1, lrclk1, dac1} !== 4'b0) begin
      errors++; $display("FAIL reset_pins1 got %b expected 0000", {mclk1, bclk1, lrclk1, dac1});
    end
    checks++;
    if (addr1 !== 32'h0) begin
      errors++; $display("FAIL reset_addr1 got %0h expected 0", addr1);
    end
    checks++;
    if ({mclk2, bclk2, lrclk2, dac2} !== 4'b0) begin
      errors++; $display("FAIL reset_pins2 got %b expected 0000", {mclk2, bclk2, lrclk2, dac2});
    end
    checks++;
    if (addr2 !== 32'h0) begin
      errors++; $display("FAIL reset_addr2 got %0h expected 0", addr2);
    end
    rstn = 1'b1;
  endtask

  task automatic test_clocks();
    logic pm, pb;
    longint last_m, last_b;
    pm = mclk1; pb = bclk1; last_m = -1; last_b = -1;
    repeat (300) begin
      @(negedge clk);
      if (mclk1 && !pm) begin
        checks++;
        if (last_m < 0 && kk != 5) begin
          errors++; $display("FAIL mclk_first_rise got %0d expected 5", kk);
        end else if (last_m >= 0 && kk - last_m != MCLK) begin
          errors++; $display("FAIL mclk_period got %0d expected %0d", kk - last_m, MCLK);
        end
        last_m = kk;
      end
      if (bclk1 && !pb) begin
        checks++;
        if (last_b < 0 && kk != 17) begin
          errors++; $display("FAIL bclk_first_rise got %0d expected 17", kk);
        end else if (last_b >= 0 && kk - last_b != BCLK) begin
          errors++; $display("FAIL bclk_period got %0d expected %0d", kk - last_b, BCLK);
        end
        last_b = kk;
      end
      if (bclk1 != pb) begin
        checks++;
        if (mclk1 == pm) begin
          errors++; $display("FAIL bclk_mclk_align at k=%0d mclk got %b expected %b", kk, mclk1, !pm);
        end
      end
      pm = mclk1; pb = bclk1;
    end
    checks++;
    if (last_m < 0 || last_b < 0) begin
      errors++; $display("FAIL clocks_toggle got mclk_seen=%0d bclk_seen=%0d expected 1 1",
                         last_m >= 0, last_b >= 0);
    end
  endtask

  task automatic test_frame_timing();
    logic pl, pb, fell;
    int guard, low, high, falls;
    pl = lrclk1; pb = bclk1; fell = 1'b0; guard = 0;
    while (!fell && guard < 5000) begin
      @(negedge clk); guard++;
      fell = pl && !lrclk1;
      if (!fell) begin pl = lrclk1; pb = bclk1; end
    end
    checks++;
    if (!fell) begin
      errors++; $display("FAIL lrclk_fall_timeout got none expected a falling edge"); return;
    end
    low = 1; high = 0; falls = (pb && !bclk1) ? 1 : 0;
    pl = lrclk1; pb = bclk1; fell = 1'b0; guard = 0;
    while (!fell && guard < 5000) begin
      @(negedge clk); guard++;
      fell = pl && !lrclk1;
      if (!fell) begin
        if (lrclk1) high++; else low++;
        if (pb && !bclk1) falls++;
        pl = lrclk1; pb = bclk1;
      end
    end
    checks++;
    if (!fell) begin
      errors++; $display("FAIL lrclk_period_timeout got none expected a falling edge");
    end
    checks++;
    if (low != 1024) begin errors++; $display("FAIL lrclk_low got %0d expected 1024", low); end
    checks++;
    if (high != 1024) begin errors++; $display("FAIL lrclk_high got %0d expected 1024", high); end
    checks++;
    if (falls != 64) begin errors++; $display("FAIL bclk_falls got %0d expected 64", falls); end
  endtask

  task automatic test_fetch_sequence();
    logic [63:0] obs [5];
    logic [15:0] l, r;
    logic        pad;
    longint p, f, c, fi;
    int unsigned pre1 [5]  = '{0, 1, 2, 3, 4};
    int unsigned pre2 [5]  = '{0, 1, 2, 3, 0};
    int unsigned post1 [5] = '{1, 2, 3, 4, 5};
    int unsigned post2 [5] = '{1, 2, 3, 0, 1};
    logic [15:0] exp_r [5] = '{16'h0000, 16'h0000, 16'h0001, 16'h0010, 16'h0051};
    for (int i = 0; i < 5; i++) obs[i] = '1;
    do_reset($urandom_range(2, 20));
    while (kk < 5 * FRAME) begin
      @(negedge clk);
      p = kk - 1; f = p / FRAME; c = p % FRAME;
      if (c % BCLK == BCLK / 2) obs[int'(f)][int'(c / BCLK)] = dac1;
      if (kk % FRAME == FRAME - 1) begin
        fi = kk / FRAME;
        checks++;
        if (addr1 !== pre1[int'(fi)]) begin
          errors++; $display("FAIL addr1_hold frame=%0d got %0d expected %0d", fi, addr1, pre1[int'(fi)]);
        end
        checks++;
        if (addr2 !== pre2[int'(fi)]) begin
          errors++; $display("FAIL addr2_hold frame=%0d got %0d expected %0d", fi, addr2, pre2[int'(fi)]);
        end
      end
      if (kk % FRAME == 0) begin
        fi = kk / FRAME - 1;
        checks++;
        if (addr1 !== post1[int'(fi)]) begin
          errors++; $display("FAIL addr1_step frame=%0d got %0d expected %0d", fi, addr1, post1[int'(fi)]);
        end
        checks++;
        if (addr2 !== post2[int'(fi)]) begin
          errors++; $display("FAIL addr2_wrap frame=%0d got %0d expected %0d", fi, addr2, post2[int'(fi)]);
        end
      end
    end
    for (int fr = 0; fr < 5; fr++) begin
      l = '0; r = '0; pad = 1'b0;
      for (int s = 0; s < 64; s++) begin
        if (s >= 1 && s <= 16) l[16 - s] = obs[fr][s];
        else if (s >= 33 && s <= 48) r[48 - s] = obs[fr][s];
        else pad = pad | obs[fr][s];
      end
      checks++;
      if (l !== 16'h0000) begin errors++; $display("FAIL left_word frame=%0d got %h expected 0000", fr, l); end
      checks++;
      if (r !== exp_r[fr]) begin errors++; $display("FAIL right_word frame=%0d got %h expected %h", fr, r, exp_r[fr]); end
      checks++;
      if (pad !== 1'b0) begin errors++; $display("FAIL padding frame=%0d got %b expected 0", fr, pad); end
    end
  endtask

  task automatic test_left_channel();
    logic [3:0]  e;
    logic [31:0] ea;
    logic [15:0] l, r;
    longint      p, c;
    int          bad = 0;
    l = '1; r = '1;
    while (kk < 18 * FRAME && bad < 10) begin
      @(negedge clk);
      model(kk, D1, e, ea);
      checks++;
      if ({mclk1, bclk1, lrclk1, dac1} !== e || addr1 !== ea) begin
        errors++; bad++;
        $display("FAIL stream1 k=%0d got pins=%b addr=%0d expected pins=%b addr=%0d",
                 kk, {mclk1, bclk1, lrclk1, dac1}, addr1, e, ea);
      end
      model(kk, D2, e, ea);
      checks++;
      if ({mclk2, bclk2, lrclk2, dac2} !== e || addr2 !== ea) begin
        errors++; bad++;
        $display("FAIL stream2 k=%0d got pins=%b addr=%0d expected pins=%b addr=%0d",
                 kk, {mclk2, bclk2, lrclk2, dac2}, addr2, e, ea);
      end
      p = kk - 1; c = p % FRAME;
      if (p / FRAME == 17 && c % BCLK == BCLK / 2) begin
        if (c / BCLK >= 1 && c / BCLK <= 16) l[int'(16 - c / BCLK)] = dac1;
        if (c / BCLK >= 33 && c / BCLK <= 48) r[int'(48 - c / BCLK)] = dac1;
      end
    end
    checks++;
    if (l !== 16'h0001) begin errors++; $display("FAIL left_addr16 got %h expected 0001", l); end
    checks++;
    if (r !== 16'h0000) begin errors++; $display("FAIL right_addr16 got %h expected 0000", r); end
  endtask

  task automatic test_mid_frame_reset();
    logic [3:0]  e;
    logic [31:0] ea;
    longint      target;
    int          bad;
    for (int rnd = 0; rnd < 2; rnd++) begin
      do_reset(3);
      bad = 0;
      target = (rnd == 0) ? 3 * FRAME + 700
                          : longint'($urandom_range(1, 2)) * FRAME + longint'($urandom_range(1, 2046));
      for (int phase = 0; phase < 2; phase++) begin
        while (kk < ((phase == 0) ? target : FRAME + 400) && bad < 10) begin
          @(negedge clk);
          model(kk, D1, e, ea);
          checks++;
          if ({mclk1, bclk1, lrclk1, dac1} !== e || addr1 !== ea) begin
            errors++; bad++;
            $display("FAIL restart1 round=%0d k=%0d got pins=%b addr=%0d expected pins=%b addr=%0d",
                     rnd, kk, {mclk1, bclk1, lrclk1, dac1}, addr1, e, ea);
          end
          model(kk, D2, e, ea);
          checks++;
          if ({mclk2, bclk2, lrclk2, dac2} !== e || addr2 !== ea) begin
            errors++; bad++;
            $display("FAIL restart2 round=%0d k=%0d got pins=%b addr=%0d expected pins=%b addr=%0d",
                     rnd, kk, {mclk2, bclk2, lrclk2, dac2}, addr2, e, ea);
          end
        end
        if (phase == 0) begin
          rstn = 1'b0;
          @(negedge clk);
          checks++;
          if ({mclk1, bclk1, lrclk1, dac1, mclk2, bclk2, lrclk2, dac2} !== 8'b0 ||
              addr1 !== 32'h0 || addr2 !== 32'h0) begin
            errors++;
            $display("FAIL abort_reset round=%0d got pins=%b%b addr=%0d/%0d expected all 0",
                     rnd, {mclk1, bclk1, lrclk1, dac1}, {mclk2, bclk2, lrclk2, dac2}, addr1, addr2);
          end
          rstn = 1'b1;
        end
      end
    end
  endtask

  initial begin
    for (int i = 0; i < 64; i++) mem[i] = $urandom;
    for (int i = 0; i < 5; i++) mem[i] = 32'(i * i * i * i);
    mem[16] = 32'(16 * 16 * 16 * 16);
    test_reset();
    test_clocks();
    test_frame_timing();
    test_fetch_sequence();
    test_left_channel();
    test_mid_frame_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
